// File: rtl/pls_hpi_pkg.sv
// Shared types and constants for the OTG host port interface sequencer.
package pls_hpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_DONE,
    ST_RECOVER
  } hpi_state_e;

  // HPI register select values driven onto hpi_addr
  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDR    = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  localparam int CNT_W = 8;

endpackage

// File: rtl/pls_hpi_sync.sv
// Two-flop synchroniser with asynchronous active-low reset.
module pls_hpi_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] i_async,
  output logic [W-1:0] o_sync
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // metastability stage followed by the settled stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/pls_otg_hpi_ctrl.sv
// Avalon-MM slave that turns each access into one timed CY7C67200 HPI bus
// cycle, plus a synchronised copy of the HPI interrupt.
//
//   state   | meaning
//   IDLE    | waiting for a request; request fields latched on accept
//   SETUP   | cs_n low, address (and write data) driven, strobes high
//   STROBE  | r_n or w_n low; read data captured on the last edge
//   HOLD    | strobes high, cs_n/address/data held
//   DONE    | one cycle, waitrequest low, readdata valid
//   RECOVER | bus idle, new requests held off
module pls_otg_hpi_ctrl
  import pls_hpi_pkg::*;
#(
  parameter int SETUP_CYC    = 2,
  parameter int STROBE_CYC   = 4,
  parameter int HOLD_CYC     = 1,
  parameter int RECOVERY_CYC = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        avs_chipselect,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic        irq,
  output logic        hpi_cs_n,
  output logic        hpi_r_n,
  output logic        hpi_w_n,
  output logic [1:0]  hpi_addr,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  input  logic [15:0] hpi_data_in,
  input  logic        otg_hpi_int
);

  localparam logic [CNT_W-1:0] L_SETUP  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] L_STROBE = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] L_HOLD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] L_RECOV  = CNT_W'(RECOVERY_CYC - 1);

  hpi_state_e       r_state;
  hpi_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic        w_req;
  logic        w_accept;
  logic        w_cnt_zero;
  logic        w_wr_nxt;
  logic        w_active_nxt;
  logic        w_strobe_nxt;
  logic        w_unused_wdata_hi;

  logic        r_wr;
  logic [1:0]  r_addr;
  logic [15:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_cs_n;
  logic        r_r_n;
  logic        r_w_n;
  logic        r_oe;

  // simultaneous read and write is treated as a write
  assign w_req        = avs_chipselect & (avs_read | avs_write);
  assign w_accept     = (r_state == ST_IDLE) & w_req;
  assign w_cnt_zero   = (r_cnt == '0);
  assign w_wr_nxt     = w_accept ? avs_write : r_wr;
  assign w_active_nxt = (w_state_nxt == ST_SETUP) | (w_state_nxt == ST_STROBE) |
                        (w_state_nxt == ST_HOLD);
  assign w_strobe_nxt = (w_state_nxt == ST_STROBE);
  assign w_unused_wdata_hi = ^avs_writedata[31:16];

  // next-state and shared down-counter reload
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt - CNT_W'(1);
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = r_cnt;
        if (w_req) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = L_SETUP;
        end
      end
      ST_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = ST_STROBE;
          w_cnt_nxt   = L_STROBE;
        end
      end
      ST_STROBE: begin
        if (w_cnt_zero) begin
          if (HOLD_CYC != 0) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = L_HOLD;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_HOLD: begin
        if (w_cnt_zero) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (RECOVERY_CYC != 0) begin
          w_state_nxt = ST_RECOVER;
          w_cnt_nxt   = L_RECOV;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RECOVER: begin
        if (w_cnt_zero) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // state register and counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // latch request fields on accept; these also drive hpi_addr/hpi_data_out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= 1'b0;
      r_addr  <= HPI_DATA;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_wr   <= avs_write;
      r_addr <= avs_address;
      if (avs_write) r_wdata <= avs_writedata[15:0];
    end
  end

  // pin registers decoded from the next state so they line up with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cs_n <= 1'b1;
      r_r_n  <= 1'b1;
      r_w_n  <= 1'b1;
      r_oe   <= 1'b0;
    end else begin
      r_cs_n <= ~w_active_nxt;
      r_r_n  <= ~(w_strobe_nxt & ~w_wr_nxt);
      r_w_n  <= ~(w_strobe_nxt & w_wr_nxt);
      r_oe   <= w_active_nxt & w_wr_nxt;
    end
  end

  // read data sampled on the edge that ends the final strobe cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if ((r_state == ST_STROBE) && w_cnt_zero && !r_wr) begin
      r_rdata <= {16'h0000, hpi_data_in};
    end
  end

  pls_hpi_sync #(.W(1)) u_irq_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (otg_hpi_int),
    .o_sync  (irq)
  );

  assign avs_waitrequest = (r_state != ST_DONE);
  assign avs_readdata    = r_rdata;
  assign hpi_cs_n        = r_cs_n;
  assign hpi_r_n         = r_r_n;
  assign hpi_w_n         = r_w_n;
  assign hpi_addr        = r_addr;
  assign hpi_data_out    = r_wdata;
  assign hpi_data_oe     = r_oe;

endmodule

// File: tb/tb_pls_otg_hpi_ctrl.sv
// Bench for pls_otg_hpi_ctrl: scoreboard on completed accesses, per-cycle
// pin expectations from the access timeline, plus a short-timing build.
module tb_pls_otg_hpi_ctrl;

  localparam int S = 2;
  localparam int T = 4;
  localparam int H = 1;
  localparam int R = 2;

  typedef struct {
    int          done_cyc;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        reset_n;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  // default build
  logic        cs_a, rd_a, wr_a, int_a;
  logic [1:0]  addr_a;
  logic [31:0] wdata_a;
  logic [31:0] rdata_a;
  logic        wait_a, irq_a, cs_n_a, r_n_a, w_n_a, oe_a;
  logic [1:0]  haddr_a;
  logic [15:0] hdout_a;
  wire  [15:0] hdin_a;

  // HOLD_CYC = 0, RECOVERY_CYC = 0 build
  logic        cs_b, rd_b, wr_b, int_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [31:0] rdata_b;
  logic        wait_b, irq_b, cs_n_b, r_n_b, w_n_b, oe_b;
  logic [1:0]  haddr_b;
  logic [15:0] hdout_b;
  logic [15:0] hdin_b;

  // reference model state
  exp_t        exp_q[$];
  exp_t        mon_e;
  int          ready;
  int          cur_acc;
  logic        cur_valid, cur_wr;
  logic [1:0]  cur_addr;
  logic [15:0] cur_data;
  logic [15:0] pad_val;
  logic [31:0] model_rd;

  int          pk;
  logic        p_cs_low, p_stb;
  logic        b_cs_low;
  int          acc_r;

  pls_otg_hpi_ctrl u_dut_a (
    .clk(clk), .reset_n(reset_n),
    .avs_chipselect(cs_a), .avs_address(addr_a), .avs_read(rd_a), .avs_write(wr_a),
    .avs_writedata(wdata_a), .avs_readdata(rdata_a), .avs_waitrequest(wait_a),
    .irq(irq_a), .hpi_cs_n(cs_n_a), .hpi_r_n(r_n_a), .hpi_w_n(w_n_a),
    .hpi_addr(haddr_a), .hpi_data_out(hdout_a), .hpi_data_oe(oe_a),
    .hpi_data_in(hdin_a), .otg_hpi_int(int_a)
  );

  pls_otg_hpi_ctrl #(.HOLD_CYC(0), .RECOVERY_CYC(0)) u_dut_b (
    .clk(clk), .reset_n(reset_n),
    .avs_chipselect(cs_b), .avs_address(addr_b), .avs_read(rd_b), .avs_write(wr_b),
    .avs_writedata(wdata_b), .avs_readdata(rdata_b), .avs_waitrequest(wait_b),
    .irq(irq_b), .hpi_cs_n(cs_n_b), .hpi_r_n(r_n_b), .hpi_w_n(w_n_b),
    .hpi_addr(haddr_b), .hpi_data_out(hdout_b), .hpi_data_oe(oe_b),
    .hpi_data_in(hdin_b), .otg_hpi_int(int_b)
  );

  // pad with an access time: true data only in the last strobe cycle
  assign hdin_a = (!r_n_a) ? (((cyc - cur_acc) == (S + T)) ? pad_val : ~pad_val) : 16'h0000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, expv);
    end
  endtask

  // pins versus the access timeline of the current transaction
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      chk("rst_pins", 32'({cs_n_a, r_n_a, w_n_a, oe_a}), 32'h0000_000E);
      chk("rst_wait", 32'(wait_a), 32'd1);
    end else begin
      pk       = cyc - cur_acc;
      p_cs_low = cur_valid && (pk >= 1) && (pk <= S + T + H);
      p_stb    = cur_valid && (pk >= S + 1) && (pk <= S + T);
      chk("pins", 32'({cs_n_a, r_n_a, w_n_a, oe_a}),
          32'({!p_cs_low, !(p_stb && !cur_wr), !(p_stb && cur_wr), p_cs_low && cur_wr}));
      if (p_cs_low) chk("hpi_addr", 32'(haddr_a), 32'(cur_addr));
      if (p_cs_low && cur_wr) chk("hpi_data_out", 32'(hdout_a), 32'(cur_data));
    end
  end

  // completion monitor
  initial forever begin
    @(negedge clk);
    if (reset_n && !wait_a) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected cyc=%0d", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
        chk("readdata", rdata_a, mon_e.rdata);
      end
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [1:0] a,
                       input logic [31:0] d, input logic [15:0] pad, input int gap);
    exp_t e;
    int   acc;
    logic got;
    cs_a = 1'b0; rd_a = 1'b0; wr_a = 1'b0;
    repeat (gap) @(negedge clk);
    acc = (cyc > ready) ? cyc : ready;
    e.done_cyc = acc + S + T + H + 1;
    if (!wr) model_rd = {16'h0000, pad};
    e.rdata = model_rd;
    ready = e.done_cyc + R + 1;
    cur_acc = acc; cur_wr = wr; cur_addr = a; cur_data = d[15:0];
    pad_val = pad; cur_valid = 1'b1;
    exp_q.push_back(e);
    cs_a = 1'b1; rd_a = rd; wr_a = wr; addr_a = a; wdata_a = d;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (!wait_a) got = 1'b1;
    end
    chk("wait_timeout", 32'(got), 32'd1);
    cs_a = 1'b0; rd_a = 1'b0; wr_a = 1'b0;
  endtask

  initial begin
    reset_n = 1'b1;
    cs_a = 0; rd_a = 0; wr_a = 0; addr_a = 0; wdata_a = 0; int_a = 0;
    cs_b = 0; rd_b = 0; wr_b = 0; addr_b = 0; wdata_b = 0; int_b = 0; hdin_b = 0;
    cur_valid = 0; cur_wr = 0; cur_addr = 0; cur_data = 0; cur_acc = 0;
    pad_val = 0; model_rd = 0; ready = 0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_cs_n", 32'(cs_n_a), 32'd1);
    chk("rst_r_n", 32'(r_n_a), 32'd1);
    chk("rst_w_n", 32'(w_n_a), 32'd1);
    chk("rst_oe", 32'(oe_a), 32'd0);
    chk("rst_addr", 32'(haddr_a), 32'd0);
    chk("rst_dout", 32'(hdout_a), 32'd0);
    chk("rst_readdata", rdata_a, 32'd0);
    chk("rst_irq", 32'(irq_a), 32'd0);
    chk("rst_waitreq", 32'(wait_a), 32'd1);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    ready = cyc;

    // short-timing build: DONE at 7, held request re-accepted at 8
    @(negedge clk);
    cs_b = 1'b1; wr_b = 1'b1; addr_b = 2'd1; wdata_b = 32'h5555C0DE;
    for (int k = 0; k <= 16; k++) begin
      b_cs_low = ((k >= 1) && (k <= 6)) || ((k >= 9) && (k <= 14));
      chk("b_cs_n", 32'(cs_n_b), 32'(!b_cs_low));
      chk("b_oe", 32'(oe_b), 32'(b_cs_low));
      chk("b_waitreq", 32'(wait_b), 32'(!((k == 7) || (k == 15))));
      chk("b_r_n", 32'(r_n_b), 32'd1);
      if (b_cs_low) begin
        chk("b_addr", 32'(haddr_b), 32'd1);
        chk("b_dout", 32'(hdout_b), 32'h0000C0DE);
      end
      if (k == 15) begin
        cs_b = 1'b0; wr_b = 1'b0;
      end
      @(negedge clk);
    end
    chk("b_readdata", rdata_b, 32'd0);
    chk("b_irq", 32'(irq_b), 32'd0);

    // directed accesses on the default build
    issue(1'b0, 1'b1, 2'd2, 32'h1234ABCD, 16'h0000, 0);
    issue(1'b1, 1'b0, 2'd0, 32'h0, 16'h5A5A, 2);
    issue(1'b0, 1'b1, 2'd1, 32'h11112222, 16'h0000, 1);
    issue(1'b0, 1'b1, 2'd3, 32'h33334444, 16'h0000, 0);
    issue(1'b1, 1'b1, 2'd2, 32'h0000BEEF, 16'h1357, 0);
    issue(1'b1, 1'b0, 2'd3, 32'h0, 16'hC3A5, 0);

    // randomized accesses
    for (int n = 0; n < 40; n++) begin
      int op;
      op = int'($urandom_range(0, 3));
      issue((op == 0) || (op == 2) || (op == 3), (op == 1) || (op == 2),
            2'($urandom_range(0, 3)), $urandom, 16'($urandom),
            int'($urandom_range(0, 2)));
    end

    // reset in the middle of a write strobe
    acc_r = (cyc > ready) ? cyc : ready;
    cur_acc = acc_r; cur_wr = 1'b1; cur_addr = 2'd3; cur_data = 16'h7777; cur_valid = 1'b1;
    cs_a = 1'b1; wr_a = 1'b1; addr_a = 2'd3; wdata_a = 32'h00007777;
    for (int i = 0; i < 30 && (cyc < acc_r + 4); i++) @(negedge clk);
    chk("rst_test_at_strobe", 32'(w_n_a), 32'd0);
    #2;
    cur_valid = 1'b0; cs_a = 1'b0; wr_a = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_w_n", 32'(w_n_a), 32'd1);
    chk("midrst_cs_n", 32'(cs_n_a), 32'd1);
    chk("midrst_oe", 32'(oe_a), 32'd0);
    chk("midrst_waitreq", 32'(wait_a), 32'd1);
    repeat (2) @(negedge clk);
    chk("midrst_readdata", rdata_a, 32'd0);
    #2 reset_n = 1'b1;
    ready = cyc;
    model_rd = 32'd0;
    repeat (12) @(negedge clk);
    issue(1'b0, 1'b1, 2'd0, 32'hFFFF0001, 16'h0000, 0);
    issue(1'b1, 1'b0, 2'd1, 32'h0, 16'h0F0F, 1);

    // interrupt pulse of three cycles
    @(negedge clk);
    int_a = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) int_a = 1'b0;
      chk("irq", 32'(irq_a), 32'((i >= 2) && (i <= 4)));
      @(negedge clk);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pls_otg_hpi_ctrl.md
Name: pls_otg_hpi_ctrl

Overview:
- Hardware sequencer for the CY7C67200 OTG host port interface (HPI).
- Replaces software bit-banging of the HPI chip-select, strobe, address and data PIOs with one Avalon-MM slave. Each slave access becomes one timed HPI bus cycle.
- Sits between the Nios II system interconnect and the OTG pins. It also synchronises the HPI interrupt line into the system clock domain.

Parameters:
- SETUP_CYC, 2, cycles from cs_n low / address valid to strobe low; legal range 1..255.
- STROBE_CYC, 4, cycles r_n or w_n is held low; legal range 1..255.
- HOLD_CYC, 1, cycles after strobe rises with cs_n, address and write data held; 0..255, 0 skips the HOLD state.
- RECOVERY_CYC, 2, idle cycles after DONE before the next request is accepted; 0..255, 0 skips the RECOVER state.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- avs_chipselect  in  1  slave select.
- avs_address  in  2  HPI register select, driven onto hpi_addr: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- avs_read  in  1  read request.
- avs_write  in  1  write request.
- avs_writedata  in  32  bits [15:0] are written to HPI; bits [31:16] are ignored.
- avs_readdata  out  32  {16'b0, captured HPI data}.
- avs_waitrequest  out  1  stalls the master until the HPI cycle completes.
- irq  out  1  synchronised otg_hpi_int.
- hpi_cs_n  out  1  HPI chip select, active low.
- hpi_r_n  out  1  HPI read strobe, active low.
- hpi_w_n  out  1  HPI write strobe, active low.
- hpi_addr  out  2  HPI register address.
- hpi_data_out  out  16  write data toward the pad.
- hpi_data_oe  out  1  pad output enable; the tristate buffer lives at top level.
- hpi_data_in  in  16  data from the pad.
- otg_hpi_int  in  1  asynchronous HPI interrupt.

Behaviour:
- All registers reset asynchronously on reset_n low. Reset values:
  - hpi_cs_n, hpi_r_n, hpi_w_n = 1.
  - hpi_data_oe = 0; hpi_addr = 0; hpi_data_out = 0.
  - avs_readdata = 0; irq = 0; avs_waitrequest = 1.
  - FSM = IDLE.
- All HPI outputs are registered, so the pins are glitch-free.
- Request: avs_chipselect & (avs_read | avs_write).
  - If avs_read and avs_write are both high, the access is a write.
- avs_waitrequest = (state != DONE), combinational from the state register.
- FSM states are IDLE, SETUP, STROBE, HOLD, DONE, RECOVER. Each timed state uses one shared 8-bit down-counter, loaded on entry with (param - 1).
- IDLE:
  - On a request, latch the address, direction and writedata[15:0].
  - Go to SETUP on the next edge; the accept edge is cycle 0.
- SETUP (SETUP_CYC cycles):
  - hpi_cs_n = 0, hpi_addr driven.
  - For writes, hpi_data_oe = 1 and hpi_data_out is valid.
  - Both strobes are high.
- STROBE (STROBE_CYC cycles):
  - hpi_r_n = 0 for reads, hpi_w_n = 0 for writes.
  - Reads capture hpi_data_in into avs_readdata on the clock edge that ends the last STROBE cycle.
- HOLD (HOLD_CYC cycles): strobes high; cs_n, address and write data/oe unchanged.
- DONE (exactly 1 cycle):
  - hpi_cs_n = 1, hpi_data_oe = 0.
  - avs_waitrequest = 0; avs_readdata is valid (reads).
  - Exit to RECOVER, or to IDLE if RECOVERY_CYC = 0.
- RECOVER (RECOVERY_CYC cycles): all HPI signals inactive; requests are held off by waitrequest. Then IDLE.
- Write cycles leave avs_readdata unchanged.
- Total latency from accept to the DONE cycle is SETUP_CYC + STROBE_CYC + HOLD_CYC + 1. With defaults, DONE is cycle 8.
- hpi_r_n and hpi_w_n are never both low. hpi_data_oe is never high during a read.
- A reset asserted mid-cycle forces every output inactive immediately, without waiting for a clock edge. The aborted access is lost, and the FSM resumes from IDLE after release.
- irq: two-flop synchroniser on otg_hpi_int, giving 2-cycle latency; it is not masked.

Decomposition:
- Package pls_hpi_pkg holds:
  - the state enum;
  - the HPI register constants HPI_DATA=0, HPI_MAILBOX=1, HPI_ADDR=2, HPI_STATUS=3;
  - the counter width CNT_W=8.
- One sub-module, pls_hpi_sync: a parameterised-width two-flop synchroniser with asynchronous reset, used for irq.

Test Plan:
- Write, address 2, writedata 0x1234ABCD, defaults:
  - hpi_addr = 2, hpi_data_out = 0xABCD.
  - cs_n low cycles 1–7; w_n low cycles 3–6 only; oe high cycles 1–7.
  - waitrequest low only in cycle 8; r_n stays high.
- Read, address 0, pad model drives 0x5A5A while r_n is low:
  - r_n low for 4 cycles; oe never high.
  - avs_readdata = 0x00005A5A during the DONE cycle (cycle 8).
- Back-to-back writes held by the master:
  - cs_n high for at least 3 cycles between accesses (DONE + 2 RECOVER).
  - Second accept edge at cycle 11.
- Reset asserted during STROBE, cycle 4:
  - w_n, cs_n = 1 and oe = 0 before the next edge; waitrequest = 1.
  - After release, no strobe occurs without a new request.
- avs_read and avs_write both high, writedata 0x0000BEEF: a write cycle with data 0xBEEF; r_n never low.
- Build with HOLD_CYC = 0, RECOVERY_CYC = 0: DONE at cycle 7, next accept at cycle 8.
- otg_hpi_int pulse of 3 cycles: irq high 2 cycles later, for 3 cycles.
